// File: rtl/reg_stat_pkg.sv
// Shared types, defaults and helpers for the multi-slot register-status table.
package reg_stat_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_REG_COUNT = 32;
  localparam int DEF_AW        = 5;
  localparam int DEF_TAG_W     = 4;

  // Upper bound on REG_COUNT that popcount can handle.
  localparam int MAX_REGS = 256;
  localparam int CNT_W    = $clog2(MAX_REGS + 1);

  // A tag of zero means the register holds a valid, committed value.
  localparam logic [DEF_TAG_W-1:0] UNLOCKED = '0;

  typedef logic [DEF_XLEN-1:0]  word_t;
  typedef logic [DEF_AW-1:0]    regaddr_t;
  typedef logic [DEF_TAG_W-1:0] regtag_t;

  // Counts set bits in a zero-padded busy vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_REGS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_REGS; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rs_read_resolve.sv
// Resolves one source read port: immediate, r0, intra-bundle rename,
// writeback bypass, then stored value, in that priority order.
module rs_read_resolve
  import reg_stat_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int AW    = DEF_AW,
  parameter int TAG_W = DEF_TAG_W,
  parameter int NDISP = 2,
  parameter int NWB   = 3,
  parameter int SLOT  = 0
) (
  input  logic                   rd_en,
  input  logic [AW-1:0]          rd_addr,
  input  logic [XLEN-1:0]        imm,
  input  logic [XLEN-1:0]        stored_data,
  input  logic [TAG_W-1:0]       stored_tag,
  input  logic [NDISP-1:0]       ren_en,
  input  logic [NDISP*AW-1:0]    ren_addr,
  input  logic [NDISP*TAG_W-1:0] ren_tag,
  input  logic [NWB-1:0]         wb_en,
  input  logic [NWB*TAG_W-1:0]   wb_tag,
  input  logic [NWB*XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]        rd_data,
  output logic [TAG_W-1:0]       rd_tag
);

  logic             fwd_hit;
  logic [TAG_W-1:0] fwd_tag;
  logic             wb_hit;
  logic [XLEN-1:0]  wb_val;

  // Pick the forwarding rename (highest earlier slot) and the bypass value (lowest wb port).
  always_comb begin
    fwd_hit = 1'b0;
    fwd_tag = TAG_W'(UNLOCKED);
    for (int j = 0; j < NDISP; j++) begin
      if ((j < SLOT) && ren_en[j] && (ren_addr[j*AW +: AW] == rd_addr)) begin
        fwd_hit = 1'b1;
        fwd_tag = ren_tag[j*TAG_W +: TAG_W];
      end
    end

    wb_hit = 1'b0;
    wb_val = '0;
    for (int p = NWB - 1; p >= 0; p--) begin
      if (wb_en[p] && (wb_tag[p*TAG_W +: TAG_W] == stored_tag)) begin
        wb_hit = 1'b1;
        wb_val = wb_data[p*XLEN +: XLEN];
      end
    end

    rd_data = stored_data;
    rd_tag  = stored_tag;
    if (!rd_en) begin
      rd_data = imm;
      rd_tag  = TAG_W'(UNLOCKED);
    end else if (rd_addr == '0) begin
      rd_data = '0;
      rd_tag  = TAG_W'(UNLOCKED);
    end else if (fwd_hit) begin
      rd_data = '0;
      rd_tag  = fwd_tag;
    end else if ((stored_tag != TAG_W'(UNLOCKED)) && wb_hit) begin
      rd_data = wb_val;
      rd_tag  = TAG_W'(UNLOCKED);
    end
  end

endmodule

// File: rtl/reg_stat_multi.sv
// Multi-slot register-status table: value and producer tag per register,
// tag-matched writeback retirement, flush and a registered busy count.
module reg_stat_multi
  import reg_stat_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int REG_COUNT = DEF_REG_COUNT,
  parameter int AW        = DEF_AW,
  parameter int TAG_W     = DEF_TAG_W,
  parameter int NDISP     = 2,
  parameter int NWB       = 3,
  parameter int CW        = $clog2(REG_COUNT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic [NDISP-1:0]         disp_en,
  input  logic [NDISP*AW-1:0]      disp_addr,
  input  logic [NDISP*TAG_W-1:0]   disp_tag,
  input  logic [NDISP*XLEN-1:0]    disp_imm,
  output logic [NDISP*TAG_W-1:0]   old_tag,
  input  logic [2*NDISP-1:0]       rd_en,
  input  logic [2*NDISP*AW-1:0]    rd_addr,
  output logic [2*NDISP*XLEN-1:0]  rd_data,
  output logic [2*NDISP*TAG_W-1:0] rd_tag,
  input  logic [NWB-1:0]           wb_en,
  input  logic [NWB*TAG_W-1:0]     wb_tag,
  input  logic [NWB*XLEN-1:0]      wb_data,
  output logic [CW-1:0]            busy_cnt
);

  logic [XLEN-1:0]     data_q [REG_COUNT];
  logic [XLEN-1:0]     data_d [REG_COUNT];
  logic [TAG_W-1:0]    tag_q  [REG_COUNT];
  logic [TAG_W-1:0]    tag_d  [REG_COUNT];
  logic [CW-1:0]       busy_cnt_q;
  logic [CW-1:0]       busy_cnt_d;
  logic [MAX_REGS-1:0] busy_vec;

  // Per-register next state: tag-matched retirement, then renames (highest slot last), then flush.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      data_d[r] = data_q[r];
      tag_d[r]  = tag_q[r];
      if (r == 0) begin
        data_d[r] = '0;
        tag_d[r]  = '0;
      end else begin
        if (tag_q[r] != '0) begin
          for (int p = NWB - 1; p >= 0; p--) begin
            if (wb_en[p] && (wb_tag[p*TAG_W +: TAG_W] == tag_q[r])) begin
              data_d[r] = wb_data[p*XLEN +: XLEN];
              tag_d[r]  = '0;
            end
          end
        end
        for (int s = 0; s < NDISP; s++) begin
          if (disp_en[s] && (disp_addr[s*AW +: AW] == AW'(r))) begin
            tag_d[r] = disp_tag[s*TAG_W +: TAG_W];
          end
        end
        if (flush) begin
          tag_d[r] = '0;
        end
      end
      busy_vec[r] = (tag_d[r] != '0);
    end
    busy_cnt_d = CW'(popcount(busy_vec));
  end

  // State update; rdy low freezes everything including flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_cnt_q <= '0;
    end else if (rdy) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Stored tag of each slot's destination, blind to this bundle and to writebacks.
  always_comb begin
    old_tag = '0;
    for (int s = 0; s < NDISP; s++) begin
      if (disp_en[s]) begin
        old_tag[s*TAG_W +: TAG_W] = tag_q[disp_addr[s*AW +: AW]];
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < 2 * NDISP; k++) begin : g_rd
    rs_read_resolve #(
      .XLEN  (XLEN),
      .AW    (AW),
      .TAG_W (TAG_W),
      .NDISP (NDISP),
      .NWB   (NWB),
      .SLOT  (k / 2)
    ) u_resolve (
      .rd_en       (rd_en[k]),
      .rd_addr     (rd_addr[k*AW +: AW]),
      .imm         (disp_imm[(k/2)*XLEN +: XLEN]),
      .stored_data (data_q[rd_addr[k*AW +: AW]]),
      .stored_tag  (tag_q[rd_addr[k*AW +: AW]]),
      .ren_en      (disp_en),
      .ren_addr    (disp_addr),
      .ren_tag     (disp_tag),
      .wb_en       (wb_en),
      .wb_tag      (wb_tag),
      .wb_data     (wb_data),
      .rd_data     (rd_data[k*XLEN +: XLEN]),
      .rd_tag      (rd_tag[k*TAG_W +: TAG_W])
    );
  end

endmodule

// File: tb/tb_reg_stat_multi.sv
// Directed testbench for reg_stat_multi: a table of combinational read-resolution
// vectors plus hand-written multi-cycle sequences.
module tb_reg_stat_multi;
  import reg_stat_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic [1:0]  disp_en;
  logic [9:0]  disp_addr;
  logic [7:0]  disp_tag;
  logic [63:0] disp_imm;
  logic [7:0]  old_tag;
  logic [3:0]  rd_en;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [15:0] rd_tag;
  logic [2:0]  wb_en;
  logic [11:0] wb_tag;
  logic [95:0] wb_data;
  logic [5:0]  busy_cnt;

  int checks;
  int failures;

  typedef struct {
    string    name;
    int       port;
    logic     rd_en;
    regaddr_t addr;
    logic [1:0] d_en;
    regaddr_t d_addr0;
    regtag_t  d_tag0;
    regaddr_t d_addr1;
    regtag_t  d_tag1;
    word_t    imm0;
    word_t    imm1;
    logic [2:0] w_en;
    regtag_t  w_tag0;
    word_t    w_data0;
    regtag_t  w_tag1;
    word_t    w_data1;
    regtag_t  w_tag2;
    word_t    w_data2;
    word_t    exp_data;
    regtag_t  exp_tag;
  } vec_t;

  vec_t vecs [12];

  reg_stat_multi dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .disp_en   (disp_en),
    .disp_addr (disp_addr),
    .disp_tag  (disp_tag),
    .disp_imm  (disp_imm),
    .old_tag   (old_tag),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .wb_en     (wb_en),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .busy_cnt  (busy_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags a zero tag on an enabled dispatch slot.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (disp_en[s]) begin
          assert (disp_tag[s*4 +: 4] != 4'd0)
            else $error("[TB] protocol violation: zero disp_tag on slot %0d", s);
        end
      end
    end
  end

  function automatic logic [31:0] rdd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rdt(input int k);
    return {28'd0, rd_tag[k*4 +: 4]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    flush     = 1'b0;
    disp_en   = '0;
    disp_addr = '0;
    disp_tag  = '0;
    disp_imm  = '0;
    rd_en     = '0;
    rd_addr   = '0;
    wb_en     = '0;
    wb_tag    = '0;
    wb_data   = '0;
  endtask

  task automatic set_disp(input int s, input int addr, input int tag);
    disp_en[s]          = 1'b1;
    disp_addr[s*5 +: 5] = 5'(addr);
    disp_tag[s*4 +: 4]  = 4'(tag);
  endtask

  task automatic set_rd(input int k, input int addr);
    rd_en[k]          = 1'b1;
    rd_addr[k*5 +: 5] = 5'(addr);
  endtask

  task automatic set_wb(input int p, input int tag, input logic [31:0] data);
    wb_en[p]            = 1'b1;
    wb_tag[p*4 +: 4]    = 4'(tag);
    wb_data[p*32 +: 32] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clear_inputs();
    rd_en[v.port]          = v.rd_en;
    rd_addr[v.port*5 +: 5] = v.addr;
    disp_en                = v.d_en;
    disp_addr              = {v.d_addr1, v.d_addr0};
    disp_tag               = {v.d_tag1, v.d_tag0};
    disp_imm               = {v.imm1, v.imm0};
    wb_en                  = v.w_en;
    wb_tag                 = {v.w_tag2, v.w_tag1, v.w_tag0};
    wb_data                = {v.w_data2, v.w_data1, v.w_data0};
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Read-resolution vectors, evaluated against the state left after sequence 3:
    // r3=0x11/tag8, r5=0xDEAD/tag0, r7=0x77/tag2, r9=0/tag6.
    vecs[0]  = '{"imm_slot0",      1, 1'b0, 5'd7, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h1234, 32'h0,    3'b000, 4'd0, 32'h0,  4'd0, 32'h0,  4'd0, 32'h0,  32'h1234, 4'd0};
    vecs[1]  = '{"imm_slot1",      3, 1'b0, 5'd7, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h1111, 32'h5678, 3'b000, 4'd0, 32'h0,  4'd0, 32'h0,  4'd0, 32'h0,  32'h5678, 4'd0};
    vecs[2]  = '{"r0_read",        2, 1'b1, 5'd0, 2'b01, 5'd0, 4'd5,  5'd0, 4'd0,  32'h0,    32'h0,    3'b000, 4'd0, 32'h0,  4'd0, 32'h0,  4'd0, 32'h0,  32'h0,    4'd0};
    vecs[3]  = '{"fwd_over_wb",    2, 1'b1, 5'd7, 2'b01, 5'd7, 4'd11, 5'd0, 4'd0,  32'h0,    32'h0,    3'b001, 4'd2, 32'h55, 4'd0, 32'h0,  4'd0, 32'h0,  32'h0,    4'd11};
    vecs[4]  = '{"slot0_no_fwd",   0, 1'b1, 5'd7, 2'b01, 5'd7, 4'd11, 5'd0, 4'd0,  32'h0,    32'h0,    3'b001, 4'd2, 32'h55, 4'd0, 32'h0,  4'd0, 32'h0,  32'h55,   4'd0};
    vecs[5]  = '{"wb_lowest_port", 1, 1'b1, 5'd9, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h0,    32'h0,    3'b110, 4'd0, 32'h0,  4'd6, 32'h61, 4'd6, 32'h62, 32'h61,   4'd0};
    vecs[6]  = '{"wb_no_match",    0, 1'b1, 5'd3, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h0,    32'h0,    3'b001, 4'd7, 32'h70, 4'd0, 32'h0,  4'd0, 32'h0,  32'h11,   4'd8};
    vecs[7]  = '{"wb_port_off",    0, 1'b1, 5'd3, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h0,    32'h0,    3'b000, 4'd8, 32'h80, 4'd0, 32'h0,  4'd0, 32'h0,  32'h11,   4'd8};
    vecs[8]  = '{"own_slot_nofwd", 2, 1'b1, 5'd9, 2'b10, 5'd0, 4'd0,  5'd9, 4'd13, 32'h0,    32'h0,    3'b000, 4'd0, 32'h0,  4'd0, 32'h0,  4'd0, 32'h0,  32'h0,    4'd6};
    vecs[9]  = '{"unlocked_nobyp", 3, 1'b1, 5'd5, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h0,    32'h0,    3'b001, 4'd0, 32'h99, 4'd0, 32'h0,  4'd0, 32'h0,  32'hDEAD, 4'd0};
    vecs[10] = '{"wb_port2",       2, 1'b1, 5'd7, 2'b00, 5'd0, 4'd0,  5'd0, 4'd0,  32'h0,    32'h0,    3'b100, 4'd0, 32'h0,  4'd0, 32'h0,  4'd2, 32'h72, 32'h72,   4'd0};
    vecs[11] = '{"fwd_addr_miss",  2, 1'b1, 5'd7, 2'b01, 5'd9, 4'd12, 5'd0, 4'd0,  32'h0,    32'h0,    3'b000, 4'd0, 32'h0,  4'd0, 32'h0,  4'd0, 32'h0,  32'h77,   4'd2};

    clear_inputs();
    rdy   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    set_rd(0, 5);
    #1;
    checkOutput("reset_busy", 32'(busy_cnt), 32'd0);
    checkOutput("reset_r5_tag", rdt(0), 32'd0);
    checkOutput("reset_r5_data", rdd(0), 32'd0);

    // Sequence 1: rename, bypass on writeback, retire
    clear_inputs();
    set_disp(0, 5, 3);
    tick();
    clear_inputs();
    set_rd(0, 5);
    #1;
    checkOutput("s1_r5_tag", rdt(0), 32'd3);
    checkOutput("s1_busy1", 32'(busy_cnt), 32'd1);
    set_wb(0, 3, 32'hDEAD);
    #1;
    checkOutput("s1_bypass_data", rdd(0), 32'hDEAD);
    checkOutput("s1_bypass_tag", rdt(0), 32'd0);
    tick();
    clear_inputs();
    set_rd(0, 5);
    #1;
    checkOutput("s1_stored_data", rdd(0), 32'hDEAD);
    checkOutput("s1_stored_tag", rdt(0), 32'd0);
    checkOutput("s1_busy0", 32'(busy_cnt), 32'd0);

    // Sequence 2: give r7 a value, then intra-bundle forwarding and same-register renames
    clear_inputs();
    set_disp(0, 7, 1);
    tick();
    clear_inputs();
    set_wb(0, 1, 32'h77);
    tick();
    clear_inputs();
    set_disp(0, 7, 2);
    disp_imm[31:0] = 32'hABCD;
    set_rd(0, 7);
    set_rd(2, 7);
    #1;
    checkOutput("s2_slot0_tag", rdt(0), 32'd0);
    checkOutput("s2_slot0_data", rdd(0), 32'h77);
    checkOutput("s2_slot1_fwd_tag", rdt(2), 32'd2);
    checkOutput("s2_slot1_fwd_data", rdd(2), 32'd0);
    checkOutput("s2_imm_port1", rdd(1), 32'hABCD);
    checkOutput("s2_old_tag0", 32'(old_tag[3:0]), 32'd0);
    tick();
    clear_inputs();
    set_disp(0, 9, 4);
    set_disp(1, 9, 6);
    tick();
    clear_inputs();
    set_rd(0, 9);
    set_rd(1, 7);
    #1;
    checkOutput("s2_r9_high_slot", rdt(0), 32'd6);
    checkOutput("s2_r7_tag", rdt(1), 32'd2);
    checkOutput("s2_busy2", 32'(busy_cnt), 32'd2);
    // Peek old_tag with rdy low so nothing is renamed
    rdy = 1'b0;
    set_disp(0, 7, 1);
    disp_en[1]      = 1'b0;
    disp_addr[9:5]  = 5'd7;
    #1;
    checkOutput("s2_old_tag_r7", 32'(old_tag[3:0]), 32'd2);
    checkOutput("s2_old_tag_off", 32'(old_tag[7:4]), 32'd0);
    tick();
    rdy = 1'b1;

    // Sequence 3: writeback and rename of the same register in one cycle
    clear_inputs();
    set_disp(0, 3, 5);
    tick();
    clear_inputs();
    set_wb(0, 5, 32'h11);
    set_disp(0, 3, 8);
    tick();
    clear_inputs();
    set_rd(0, 3);
    #1;
    checkOutput("s3_r3_data", rdd(0), 32'h11);
    checkOutput("s3_r3_tag", rdt(0), 32'd8);
    checkOutput("s3_busy3", 32'(busy_cnt), 32'd3);

    // Table-driven read resolution with rdy low so the state stays put
    rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_data"}, rdd(vecs[i].port), vecs[i].exp_data);
      checkOutput({vecs[i].name, "_tag"}, rdt(vecs[i].port), 32'(vecs[i].exp_tag));
    end
    clear_inputs();
    tick();
    rdy = 1'b1;
    checkOutput("table_state_kept", 32'(busy_cnt), 32'd3);

    // Sequence 4: retire everything, lock r1/r2/r4, then flush
    clear_inputs();
    set_wb(0, 2, 32'hA7);
    set_wb(1, 6, 32'hA9);
    set_wb(2, 8, 32'hA3);
    tick();
    clear_inputs();
    #1;
    checkOutput("s4_all_retired", 32'(busy_cnt), 32'd0);
    set_disp(0, 1, 1);
    set_disp(1, 2, 2);
    tick();
    clear_inputs();
    set_disp(0, 4, 4);
    tick();
    clear_inputs();
    #1;
    checkOutput("s4_busy3", 32'(busy_cnt), 32'd3);
    flush = 1'b1;
    set_wb(0, 2, 32'h22);
    set_disp(0, 6, 7);
    tick();
    clear_inputs();
    set_rd(0, 2);
    set_rd(1, 1);
    set_rd(2, 6);
    set_rd(3, 4);
    #1;
    checkOutput("s4_r2_data", rdd(0), 32'h22);
    checkOutput("s4_r2_tag", rdt(0), 32'd0);
    checkOutput("s4_r1_tag", rdt(1), 32'd0);
    checkOutput("s4_r6_tag", rdt(2), 32'd0);
    checkOutput("s4_r4_tag", rdt(3), 32'd0);
    checkOutput("s4_busy0", 32'(busy_cnt), 32'd0);

    // Sequence 5: rdy low freezes rename, writeback and flush
    clear_inputs();
    set_disp(0, 10, 9);
    tick();
    clear_inputs();
    rdy   = 1'b0;
    flush = 1'b1;
    set_disp(0, 11, 3);
    set_wb(0, 9, 32'h99);
    set_rd(0, 10);
    #1;
    checkOutput("s5_frozen_bypass", rdd(0), 32'h99);
    repeat (2) tick();
    clear_inputs();
    set_rd(0, 10);
    set_rd(1, 11);
    #1;
    checkOutput("s5_r10_tag_kept", rdt(0), 32'd9);
    checkOutput("s5_r10_data_kept", rdd(0), 32'd0);
    checkOutput("s5_r11_tag_kept", rdt(1), 32'd0);
    checkOutput("s5_busy_kept", 32'(busy_cnt), 32'd1);
    rdy = 1'b1;
    set_wb(0, 9, 32'h99);
    tick();
    clear_inputs();
    set_rd(0, 10);
    #1;
    checkOutput("s5_resume_data", rdd(0), 32'h99);
    checkOutput("s5_resume_tag", rdt(0), 32'd0);
    checkOutput("s5_resume_busy", 32'(busy_cnt), 32'd0);

    // Sequence 6: asynchronous reset mid-cycle, then r0 behaviour
    clear_inputs();
    set_disp(0, 12, 3);
    set_disp(1, 13, 4);
    tick();
    clear_inputs();
    set_rd(0, 12);
    set_rd(1, 7);
    #1;
    checkOutput("s6_busy2", 32'(busy_cnt), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_async_busy", 32'(busy_cnt), 32'd0);
    checkOutput("s6_async_r12_tag", rdt(0), 32'd0);
    checkOutput("s6_async_r7_data", rdd(1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    set_disp(0, 0, 5);
    set_rd(2, 0);
    #1;
    checkOutput("s6_r0_fwd_tag", rdt(2), 32'd0);
    tick();
    clear_inputs();
    set_rd(0, 0);
    #1;
    checkOutput("s6_r0_data", rdd(0), 32'd0);
    checkOutput("s6_r0_tag", rdt(0), 32'd0);
    checkOutput("s6_r0_busy", 32'(busy_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_stat_multi.md
Name: reg_stat_multi

Overview:
- Parametrised register-status table for the Tomasulo dispatch stage. Generalises the single-slot version.
- Holds the architectural value and the producer tag of every register. Serves NDISP dispatch slots, each with two source reads and one destination rename.
- Retires results from NWB broadcast writeback ports by associative tag match, not by register address.
- Adds same-cycle writeback-to-read bypass, intra-bundle rename forwarding, a flush, and a registered busy-register count.

Parameters:
- XLEN, 32, data word width
- REG_COUNT, 32, number of architectural registers; register 0 is hard-wired zero
- AW, 5, register address width; equals $clog2(REG_COUNT)
- TAG_W, 4, producer tag width; tag value 0 is UNLOCKED
- NDISP, 2, dispatch slots per cycle
- NWB, 3, writeback broadcast ports

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global ready; low freezes all state
- flush  in  1  mispredict flush, synchronous
- disp_en  in  NDISP  per-slot destination rename enable
- disp_addr  in  NDISP*AW  destination register per slot
- disp_tag  in  NDISP*TAG_W  new producer tag per slot; must be nonzero
- disp_imm  in  NDISP*XLEN  immediate returned by a disabled read port of that slot
- old_tag  out  NDISP*TAG_W  current tag of disp_addr, before this cycle's renames; 0 if !disp_en
- rd_en  in  2*NDISP  source read enable; port k belongs to slot k/2
- rd_addr  in  2*NDISP*AW  source register
- rd_data  out  2*NDISP*XLEN  resolved source value
- rd_tag  out  2*NDISP*TAG_W  resolved source tag; 0 means value valid
- wb_en  in  NWB  writeback valid
- wb_tag  in  NWB*TAG_W  tag of the finishing producer
- wb_data  in  NWB*XLEN  result value
- busy_cnt  out  $clog2(REG_COUNT+1)  registered count of registers with nonzero tag

Behaviour:
- State: data[REG_COUNT], tag[REG_COUNT], busy_cnt.
- Reset (rst_n=0, asynchronous): all data=0, all tags=0, busy_cnt=0.
- Read port k, slot s, combinational. Rules apply in priority order:
  1. !rd_en[k]: data=disp_imm[s], tag=0.
  2. rd_addr==0: data=0, tag=0.
  3. Some slot j<s has disp_en[j] and disp_addr[j]==rd_addr: tag=disp_tag of the highest such j, data=0.
  4. tag[rd_addr]!=0 and some wb port p has wb_en[p] and wb_tag[p]==tag[rd_addr]: data=wb_data of the lowest such p, tag=0.
  5. Otherwise: stored data and tag.
- old_tag[s] reports the stored tag only. It ignores earlier slots in the bundle and ignores writebacks.
- Writeback, per register r, on the clock edge:
  - Applies when tag[r]!=0 and a wb port matches it; the lowest matching p wins.
  - Effect: data[r]<=wb_data, tag[r]<=0.
  - Because the match is on tag, multiple registers holding the same tag all retire together.
- Dispatch, per slot s, on the clock edge:
  - Applies when disp_en[s] and disp_addr[s]!=0.
  - Effect: tag[disp_addr[s]]<=disp_tag[s].
  - If several slots name the same register, the highest slot wins.
- Writeback and dispatch to the same register in the same cycle: data takes wb_data, tag takes the dispatch tag.
- Flush (on the clock edge):
  - Every tag is cleared to 0 and all dispatch renames are ignored.
  - Writebacks that match the pre-flush tags still update data.
- rdy=0: no state update of any kind, flush included. Read outputs stay combinational and valid.
- busy_cnt: on every enabled edge, the popcount of the next-state tag vector. Latency is 1 cycle after the change.
- Register 0: its tag and data never change from 0.
- disp_tag==0 with disp_en=1 is a protocol violation; the bench asserts on it.
- Duplicate wb_tag values across enabled wb ports are a protocol violation; if they occur, the lowest port index wins.

Decomposition:
- Package reg_stat_pkg holds:
  - UNLOCKED=0
  - default XLEN, AW, TAG_W
  - word_t, regaddr_t and regtag_t typedefs
  - a popcount function
- Sub-module rs_read_resolve, instantiated once per read port. Inputs: stored data and tag, the earlier slots' rename vectors, and the wb buses. Output: resolved rd_data and rd_tag.
- The top module owns the state arrays, the per-register next-state logic and busy_cnt.

Test Plan:
1. Reset, then slot0 renames r5 to tag 3. Next cycle read r5 -> rd_tag=3, busy_cnt=1. Then wb tag 3 with data 0xDEAD -> same-cycle read gives data 0xDEAD, tag 0. Following cycle: stored data 0xDEAD, tag 0, busy_cnt=0.
2. One bundle: slot0 renames r7 to tag 2; slot1 reads r7 -> slot1 sees rd_tag=2. Slot0 reading r7 in the same cycle gets the old stored tag 0 and its data. Both slots rename r9 (tags 4, 6) -> r9 ends with tag 6.
3. r3 holds tag 5. wb tag 5 with data 0x11 and slot0 renames r3 to tag 8 in the same cycle -> data[3]=0x11, tag[3]=8.
4. r1, r2, r4 locked, busy_cnt=3. Raise flush together with wb of r2's tag and a dispatch to r6 -> all tags 0, data[2] updated, r6 unlocked, busy_cnt=0 next cycle.
5. Hold rdy=0 while issuing a rename, a wb and a flush -> state and busy_cnt unchanged. Set rdy=1 -> state updates resume on the next edge.
6. Assert rst_n=0 between clock edges while registers are locked -> outputs clear immediately without waiting for clk. Renames to r0 and reads of r0 always return 0 and tag 0.
